// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// audio_pkg : sample/duty types and conversion shared by the audio receive
//             and playback blocks.          Rev 1.0
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int DUTY_W   = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [DUTY_W-1:0]          duty_t;

    localparam duty_t MIDSCALE = {1'b1, {(DUTY_W-1){1'b0}}};

    // Signed to offset binary by flipping the sign bit, then keep the top bits.
    function automatic duty_t to_duty(input sample_t s);
        logic [SAMPLE_W-1:0] ob;
        ob = {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
        return ob[SAMPLE_W-1 -: DUTY_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// sample_fifo : synchronous FIFO with push/pop/flush and occupancy count.
//               DEPTH must be a power of two (>= 2).      Rev 1.0
// ============================================================================
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign dout  = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/audio_pwm_out.sv
`default_nettype none
// ============================================================================
// audio_pwm_out : buffers received samples, drains them at the sample rate and
//                 renders each as a glitch-free PWM duty.       Rev 1.0
// ============================================================================
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int SAMPLE_HZ  = 48_000,
    parameter int PWM_BITS   = DUTY_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [SAMPLE_W-1:0]           sample_in,
    input  logic                          sample_valid,
    input  logic                          clear_flags,
    output logic                          pwm_out,
    output logic                          sample_tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          overflow
);

    localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int TICK_W     = $clog2(SAMPLE_DIV);
    localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS-1){1'b0}}};

    logic [TICK_W-1:0]   tick_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] next_duty;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] head_duty;
    logic [SAMPLE_W-1:0] fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                underrun_set;
    logic                overflow_set;
    logic                pwm_q;
    logic                underrun_q;
    logic                overflow_q;

    assign sample_tick  = enable && (tick_cnt == TICK_W'(SAMPLE_DIV - 1));
    assign fifo_pop     = sample_tick && !fifo_empty;
    assign fifo_push    = enable && sample_valid;
    assign underrun_set = sample_tick && fifo_empty;
    assign overflow_set = enable && sample_valid && fifo_full && !fifo_pop;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (!enable),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (sample_in),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    generate
        if (PWM_BITS == DUTY_W) begin : g_pkg_duty
            assign head_duty = to_duty(sample_t'(fifo_head));
        end else begin : g_generic_duty
            logic [SAMPLE_W-1:0] offset_bin;
            assign offset_bin = {~fifo_head[SAMPLE_W-1], fifo_head[SAMPLE_W-2:0]};
            assign head_duty  = offset_bin[SAMPLE_W-1 -: PWM_BITS];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            tick_cnt <= '0;
        end else if (sample_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // duty_q only changes at the end of a period so no pulse is ever truncated.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            pwm_cnt   <= '0;
            duty_q    <= DUTY_MID;
            next_duty <= DUTY_MID;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            pwm_q   <= (pwm_cnt < duty_q);
            if (pwm_cnt == '1) duty_q <= next_duty;
            if (sample_tick) next_duty <= fifo_pop ? head_duty : DUTY_MID;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            underrun_q <= underrun_set || (underrun_q && !clear_flags);
            overflow_q <= overflow_set || (overflow_q && !clear_flags);
        end
    end

    assign pwm_out  = pwm_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_pwm_out.sv
`default_nettype none
// ============================================================================
// tb_audio_pwm_out : self-checking bench for audio_pwm_out with a
//                    cycle-stepped queue/arithmetic reference model. Rev 1.0
// ============================================================================
module tb_audio_pwm_out;
    import audio_pkg::*;

    localparam int DIV   = 520;
    localparam int PER   = 256;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        clear_flags;
    logic        pwm_out;
    logic        sample_tick;
    logic [3:0]  fifo_level;
    logic        underrun;
    logic        overflow;

    always #20 clk = ~clk;

    audio_pwm_out dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear_flags  (clear_flags),
        .pwm_out      (pwm_out),
        .sample_tick  (sample_tick),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .overflow     (overflow)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: n = enabled clock edges since reset/disable.
    int m_n    = 0;
    int m_nd   = 128;
    int m_duty = 128;
    bit m_pwm  = 1'b0;
    bit m_uf   = 1'b0;
    bit m_ov   = 1'b0;
    int q[$];

    typedef struct {
        logic [15:0] s;
        int          hi;
    } duty_vec_t;
    duty_vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_duty(input logic [15:0] s);
        return ((int'(s) + 32768) % 65536) / 256;
    endfunction

    task automatic model_step();
        int  ph;
        int  pre;
        bit  tick;
        bit  popped;
        bit  uf_set;
        bit  ov_set;
        if (reset) begin
            m_n = 0; m_nd = 128; m_duty = 128; m_pwm = 0; m_uf = 0; m_ov = 0;
            q.delete();
        end else if (!enable) begin
            m_n = 0; m_nd = 128; m_duty = 128; m_pwm = 0;
            q.delete();
            if (clear_flags) begin m_uf = 0; m_ov = 0; end
        end else begin
            ph     = m_n % PER;
            tick   = (m_n % DIV) == DIV - 1;
            pre    = q.size();
            popped = 0; uf_set = 0; ov_set = 0;
            m_pwm  = ph < m_duty;
            if (ph == PER - 1) m_duty = m_nd;
            if (tick) begin
                if (pre > 0) begin
                    m_nd   = ref_duty(16'(q.pop_front()));
                    popped = 1;
                end else begin
                    m_nd   = 128;
                    uf_set = 1;
                end
            end
            if (sample_valid) begin
                if (pre < DEPTH || popped) q.push_back(int'(sample_in));
                else ov_set = 1;
            end
            m_uf = uf_set || (m_uf && !clear_flags);
            m_ov = ov_set || (m_ov && !clear_flags);
            m_n++;
        end
    endtask

    // One clock: model and DUT both advance, then every output is compared.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("m_pwm_out", int'(pwm_out), int'(m_pwm));
        chk("m_fifo_level", int'(fifo_level), q.size());
        chk("m_underrun", int'(underrun), int'(m_uf));
        chk("m_overflow", int'(overflow), int'(m_ov));
        chk("m_sample_tick", int'(sample_tick), int'(enable && ((m_n % DIV) == DIV - 1)));
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic start();
        enable = 0; reset = 1; sample_valid = 0; clear_flags = 0;
        run(2);
        reset = 0; enable = 1;
    endtask

    task automatic push(input logic [15:0] s);
        sample_in = s; sample_valid = 1;
        cycle();
        sample_valid = 0;
    endtask

    task automatic count_high(output int hi);
        hi = 0;
        repeat (PER) begin
            cycle();
            hi += int'(pwm_out);
        end
    endtask

    initial begin
        int hi;
        int k;
        tbl[0] = '{16'h0000, 128};
        tbl[1] = '{16'h7FFF, 255};
        tbl[2] = '{16'h8000, 0};
        tbl[3] = '{16'h1234, 146};
        tbl[4] = '{16'hFFFF, 127};
        tbl[5] = '{16'hC000, 64};

        reset = 1; enable = 0; sample_valid = 0; clear_flags = 0; sample_in = '0;
        run(3);
        reset = 0;
        run(8);
        chk("t1_pwm_out", int'(pwm_out), 0);
        chk("t1_fifo_level", int'(fifo_level), 0);
        chk("t1_underrun", int'(underrun), 0);
        chk("t1_overflow", int'(overflow), 0);

        // Single sample: duty settles within a period after the first tick.
        for (int i = 0; i < 6; i++) begin
            start();
            push(tbl[i].s);
            run(800);
            count_high(hi);
            chk($sformatf("duty_%04h_high", tbl[i].s), hi, tbl[i].hi);
            chk($sformatf("duty_%04h_level", tbl[i].s), int'(fifo_level), 0);
        end

        // Full scale followed by negative full scale on the next tick.
        start();
        push(16'h7FFF);
        push(16'h8000);
        run(798);
        count_high(hi);
        chk("t3_first_period", hi, 255);
        run(240);
        count_high(hi);
        chk("t3_second_period", hi, 0);

        // Nine pushes without a tick; the ninth must be dropped.
        start();
        for (int i = 0; i < 9; i++) push(16'(16'h1000 * i));
        chk("t4_level_full", int'(fifo_level), DEPTH);
        chk("t4_overflow_set", int'(overflow), 1);
        clear_flags = 1;
        cycle();
        clear_flags = 0;
        chk("t4_overflow_clr", int'(overflow), 0);

        // Push into a full FIFO exactly on the tick: accepted, level unchanged.
        k = 0;
        while (!sample_tick && k < 2 * DIV) begin cycle(); k++; end
        chk("t5_tick_seen", int'(sample_tick), 1);
        push(16'h4000);
        chk("t5_level", int'(fifo_level), DEPTH);
        chk("t5_overflow", int'(overflow), 0);
        run(9 * DIV + 600);
        chk("t5_drained", int'(fifo_level), 0);
        chk("t5_underrun", int'(underrun), 1);

        // Empty playback: first tick timing, underrun, midscale, reset mid-run.
        start();
        k = 0;
        while (!sample_tick && k < 2 * DIV) begin cycle(); k++; end
        chk("t6_first_tick_edges", k, DIV - 1);
        chk("t6_underrun_before", int'(underrun), 0);
        cycle();
        chk("t6_underrun_after", int'(underrun), 1);
        count_high(hi);
        chk("t6_midscale", hi, 128);
        push(16'h2222);
        reset = 1;
        cycle();
        chk("t6_rst_pwm", int'(pwm_out), 0);
        chk("t6_rst_tick", int'(sample_tick), 0);
        chk("t6_rst_level", int'(fifo_level), 0);
        chk("t6_rst_underrun", int'(underrun), 0);
        chk("t6_rst_overflow", int'(overflow), 0);
        reset = 0;

        // Randomized traffic against the reference model.
        start();
        for (int i = 0; i < 20000; i++) begin
            sample_valid = ($urandom_range(0, (i < 10000) ? 399 : 699) == 0);
            sample_in    = 16'($urandom);
            clear_flags  = ($urandom_range(0, 2999) == 0);
            enable       = !(i >= 7000 && i < 7030);
            reset        = (i == 14000 || i == 14001);
            cycle();
        end
        sample_valid = 0; clear_flags = 0; reset = 0;
        run(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_pwm_out.md
Name: audio_pwm_out

Overview:
Downstream playback stage for the SPI audio receiver. Takes the 16-bit signed samples it delivers, as single-cycle valid strobes in the 25 MHz system clock domain, and buffers them in a small synchronous FIFO. Drains the FIFO at a fixed sample rate and converts each sample to a PWM waveform that drives the board's audio output pin through an RC filter. Reports FIFO level plus sticky underrun/overflow flags for the firmware to poll.

Parameters:
CLK_HZ, 25_000_000, system clock frequency
SAMPLE_HZ, 48_000, playback sample rate
SAMPLE_DIV, CLK_HZ/SAMPLE_HZ (520), clocks per sample tick
PWM_BITS, 8, PWM resolution; carrier = CLK_HZ / 2**PWM_BITS
FIFO_DEPTH, 8, sample FIFO entries (power of two)

Ports:
clk  in  1  system clock, 25 MHz
reset  in  1  reset, synchronous, active-high
enable  in  1  playback enable; low = flush and mute
sample_in  in  16  signed two's-complement sample from receiver
sample_valid  in  1  one-cycle strobe, sample_in valid
clear_flags  in  1  one-cycle strobe, clears underrun/overflow
pwm_out  out  1  PWM audio output
sample_tick  out  1  one-cycle pulse at each sample-rate tick
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
underrun  out  1  sticky: tick occurred with FIFO empty
overflow  out  1  sticky: sample_valid while FIFO full and no pop that cycle

Behaviour:
- Reset values: pwm_out 0, sample_tick 0, fifo_level 0, underrun 0, overflow 0, tick counter 0, PWM counter 0, current duty 2**(PWM_BITS-1) (0x80).
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps. sample_tick=1 in the cycle the count equals SAMPLE_DIV-1.
- Pop: on sample_tick, if FIFO not empty, the head entry goes into next_duty. If empty, next_duty is set to midscale 0x80 and underrun is set.
- Duty conversion: invert sample MSB (signed to offset binary), keep the top PWM_BITS bits. 0x0000 gives 0x80; 0x7FFF gives 0xFF; 0x8000 gives 0x00.
- Push: sample_valid with FIFO not full writes sample_in. When full and no pop in the same cycle, the sample is dropped and overflow is set.
- Simultaneous push and pop: pop evaluates the pre-push state. When full, the push is accepted and the level is unchanged. When empty, underrun is set and the push is stored (level becomes 1).
- PWM counter: free-runs 0..2**PWM_BITS-1. duty_q loads next_duty only in the cycle the counter is at max, so there are no mid-period glitches.
- PWM output: pwm_out = registered (pwm_cnt < duty_q). Duty 0 is constant low; 0xFF is high for 255 of every 256 clocks.
- Latency: a sample popped at a tick reaches pwm_out at the first PWM period start after that tick, at most 2**PWM_BITS clocks later.
- enable low: FIFO is flushed (level 0), pushes ignored, tick and PWM counters held at 0, next_duty/duty_q held at 0x80, pwm_out 0, no flag updates. Flags still clear via clear_flags.
- Flags: clear_flags clears both flags. If a set condition happens in the same cycle as clear_flags, set wins.
- Reset mid-operation: all state returns to reset values on the next clock edge. In-flight FIFO contents are lost.

Decomposition:
- Package audio_pkg: SAMPLE_W=16; typedef sample_t (logic signed [15:0]); MIDSCALE constant; function to_duty(sample_t) returning PWM_BITS bits. The receiver shares this package.
- Sub-module sample_fifo: synchronous FIFO with push/pop/full/empty/level, parameterised on width and depth. audio_pwm_out instantiates it.

Test Plan:
1. Reset, enable=0 -> pwm_out 0, fifo_level 0, underrun 0, overflow 0 on every cycle.
2. enable=1, push 0x0000 -> after next tick and PWM wrap, pwm_out high exactly 128 of each 256 clocks; fifo_level returns 0.
3. Push 0x7FFF, then 0x8000 one tick later -> first period high 255/256 clocks, next period constant low.
4. Nine back-to-back pushes with no tick in between -> fifo_level 8, overflow 1, ninth sample never played. clear_flags -> overflow 0.
5. Fill FIFO to 8, push in the same cycle as sample_tick -> fifo_level stays 8, overflow stays 0, new sample plays last.
6. enable=1, no pushes -> first sample_tick at cycle 520 sets underrun, pwm_out at 128/256 duty. Assert reset mid-stream -> next cycle all outputs at reset values.
